// File: rtl/big_alu_pkg.sv
// Shared types and constants for the sequential big ALU.
// Opcode and FSM state encodings live here so every unit agrees on them.
package big_alu_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_MUL = 4'd8,
        OP_DIV = 4'd9
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic needs_iter(
        input logic [OPC_W-1:0] opc,
        input logic             b_zero
    );
        return (opc == OP_MUL) || ((opc == OP_DIV) && !b_zero);
    endfunction

endpackage

// File: rtl/big_alu_if.sv
// Request/response bundle for the big ALU: instruction and operands in,
// registered result and flags out, valid/ready on both sides.
interface big_alu_if #(
    parameter int WIDTH   = 8,
    parameter int INSTR_W = 16
);

    logic [INSTR_W-1:0] instruction;
    logic [WIDTH-1:0]   data0;
    logic [WIDTH-1:0]   data1;
    logic               in_valid;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   res_lo;
    logic [WIDTH-1:0]   res_hi;
    logic               of;
    logic               zf;
    logic               err;

    modport master (
        output instruction, data0, data1, in_valid, out_ready,
        input  in_ready, out_valid, res_lo, res_hi, of, zf, err
    );

    modport slave (
        input  instruction, data0, data1, in_valid, out_ready,
        output in_ready, out_valid, res_lo, res_hi, of, zf, err
    );

endinterface

// File: rtl/big_alu_iter.sv
// Shared one-bit-per-cycle datapath: shift-add multiply and restoring divide.
// The start edge performs iteration 0 on the live operands, so done fires on iteration WIDTH-1.
module big_alu_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_mul,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             mul_q, mul_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] cur_hi, cur_lo, cur_m;
    logic             cur_mul;
    logic [WIDTH:0]   sum, rem;
    logic [WIDTH-1:0] dif;
    logic             ge;

    // Multiply keeps the multiplier in lo and the multiplicand in m;
    // divide keeps the dividend in lo and the divisor in m.
    always_comb begin
        cur_hi  = start ? '0 : hi_q;
        cur_lo  = start ? (is_mul ? b : a) : lo_q;
        cur_m   = start ? (is_mul ? a : b) : m_q;
        cur_mul = start ? is_mul : mul_q;
        sum     = {1'b0, cur_hi} + {1'b0, cur_m};
        rem     = {cur_hi, cur_lo[WIDTH-1]};
        ge      = rem >= {1'b0, cur_m};
        dif     = rem[WIDTH-1:0] - cur_m;
        if (cur_mul) begin
            if (cur_lo[0]) begin
                {hi, lo} = {sum, cur_lo[WIDTH-1:1]};
            end else begin
                {hi, lo} = {1'b0, cur_hi, cur_lo[WIDTH-1:1]};
            end
        end else begin
            hi = ge ? dif : rem[WIDTH-1:0];
            lo = {cur_lo[WIDTH-2:0], ge};
        end
    end

    assign done = busy_q && (cnt_q == LAST);
    assign busy = busy_q;

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        m_d    = m_q;
        mul_d  = mul_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (start) begin
            hi_d   = hi;
            lo_d   = lo;
            m_d    = cur_m;
            mul_d  = cur_mul;
            busy_d = 1'b1;
            cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (busy_q) begin
            hi_d = hi;
            lo_d = lo;
            if (done) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            m_q    <= '0;
            mul_q  <= 1'b0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            m_q    <= m_d;
            mul_q  <= mul_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/big_alu_seq.sv
// Handshaked big ALU: single-cycle logic/arith ops plus iterative MUL/DIV.
// Results and flags are registered and held until the consumer takes them.
module big_alu_seq
    import big_alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int INSTR_W = 16
) (
    input logic      clk,
    input logic      rst_n,
    big_alu_if.slave bus
);

    localparam int SH_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             of_q, of_d;
    logic             zf_q, zf_d;
    logic             err_q, err_d;
    logic             mul_q, mul_d;

    logic [OPC_W-1:0]         opc;
    logic [WIDTH-1:0]         a, b;
    logic [INSTR_W-OPC_W-1:0] unused_instr;

    assign opc          = bus.instruction[INSTR_W-1 -: OPC_W];
    assign unused_instr = bus.instruction[INSTR_W-OPC_W-1:0];
    assign a            = bus.data0;
    assign b            = bus.data1;

    logic [WIDTH:0]     sum, dif;
    logic [2*WIDTH-1:0] shl;
    logic [WIDTH-1:0]   alu_lo, alu_hi;
    logic               alu_of, alu_err;

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        dif     = {1'b0, a} - {1'b0, b};
        shl     = {{WIDTH{1'b0}}, a} << b[SH_W-1:0];
        alu_lo  = '0;
        alu_hi  = '0;
        alu_of  = 1'b0;
        alu_err = 1'b0;
        case (opc)
            OP_ADD: begin
                alu_lo = sum[WIDTH-1:0];
                alu_hi = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
                alu_of = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_lo = dif[WIDTH-1:0];
                alu_hi = {{(WIDTH-1){1'b0}}, dif[WIDTH]};
                alu_of = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_lo = a & b;
            OP_OR:  alu_lo = a | b;
            OP_XOR: alu_lo = a ^ b;
            OP_NOT: alu_lo = ~a;
            OP_SHL: begin
                alu_lo = shl[WIDTH-1:0];
                alu_hi = shl[2*WIDTH-1:WIDTH];
                alu_of = |shl[2*WIDTH-1:WIDTH];
            end
            OP_SHR: alu_lo = a >> b[SH_W-1:0];
            // Only divide-by-zero reaches the single-cycle path here.
            OP_MUL, OP_DIV: begin
                alu_lo = '1;
                alu_hi = a;
                alu_of = 1'b1;
            end
            default: alu_err = 1'b1;
        endcase
    end

    logic             iter_start, iter_busy, iter_done;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    big_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (iter_start),
        .is_mul (opc == OP_MUL),
        .a      (a),
        .b      (b),
        .busy   (iter_busy),
        .done   (iter_done),
        .hi     (iter_hi),
        .lo     (iter_lo)
    );

    always_comb begin
        state_d    = state_q;
        res_lo_d   = res_lo_q;
        res_hi_d   = res_hi_q;
        of_d       = of_q;
        zf_d       = zf_q;
        err_d      = err_q;
        mul_d      = mul_q;
        iter_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (needs_iter(opc, b == '0)) begin
                        state_d    = CALC;
                        iter_start = 1'b1;
                        mul_d      = (opc == OP_MUL);
                    end else begin
                        state_d  = DONE;
                        res_lo_d = alu_lo;
                        res_hi_d = alu_hi;
                        of_d     = alu_of;
                        zf_d     = ~|{alu_hi, alu_lo};
                        err_d    = alu_err;
                    end
                end
            end
            CALC: begin
                if (iter_busy && iter_done) begin
                    state_d  = DONE;
                    res_lo_d = iter_lo;
                    res_hi_d = iter_hi;
                    of_d     = mul_q && (iter_hi != '0);
                    zf_d     = ~|{iter_hi, iter_lo};
                    err_d    = 1'b0;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            res_lo_q <= '0;
            res_hi_q <= '0;
            of_q     <= 1'b0;
            zf_q     <= 1'b0;
            err_q    <= 1'b0;
            mul_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            of_q     <= of_d;
            zf_q     <= zf_d;
            err_q    <= err_d;
            mul_q    <= mul_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.res_lo    = res_lo_q;
    assign bus.res_hi    = res_hi_q;
    assign bus.of        = of_q;
    assign bus.zf        = zf_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_big_alu_seq.sv
// Directed bench for big_alu_seq at WIDTH=8: hand-computed vectors,
// latency, hold-while-stalled and mid-operation reset behaviour.
module tb_big_alu_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    big_alu_if #(.WIDTH(8), .INSTR_W(16)) bus ();

    big_alu_seq #(.WIDTH(8), .INSTR_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request in IDLE, then wait (bounded) for out_valid.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output bit rdy_seen);
        bus.instruction = {op, 12'h5A5};
        bus.data0       = a;
        bus.data1       = b;
        bus.in_valid    = 1'b1;
        tick();
        bus.in_valid    = 1'b0;
        bus.data0       = ~a;
        bus.data1       = ~b;
        bus.instruction = 16'hF000;
        lat      = 1;
        rdy_seen = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            rdy_seen |= bus.in_ready;
            tick();
            lat++;
        end
        rdy_seen |= bus.in_ready;
    endtask

    task automatic run(input string tag, input logic [3:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] e_lo, input logic [7:0] e_hi,
                       input logic [2:0] e_flags, input int e_lat);
        int lat;
        bit rdy;
        send(op, a, b, lat, rdy);
        chk({tag, ".lat"}, 32'(lat), 32'(e_lat));
        chk({tag, ".rdy"}, 32'(rdy), 32'd0);
        chk({tag, ".lo"}, 32'(bus.res_lo), 32'(e_lo));
        chk({tag, ".hi"}, 32'(bus.res_hi), 32'(e_hi));
        chk({tag, ".flags"}, 32'({bus.of, bus.zf, bus.err}), 32'(e_flags));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, ".idle"}, 32'({bus.out_valid, bus.in_ready}), 32'b01);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int  lat;
        bit  rdy;
        bus.instruction = '0;
        bus.data0       = '0;
        bus.data1       = '0;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.hs", 32'({bus.in_ready, bus.out_valid}), 32'b10);
        chk("reset.lo", 32'(bus.res_lo), 32'h0);
        chk("reset.hi", 32'(bus.res_hi), 32'h0);
        chk("reset.flags", 32'({bus.of, bus.zf, bus.err}), 32'b000);
        rst_n = 1'b1;
        tick();

        // flags are {of, zf, err}
        run("add_ff_ff", 4'd0, 8'hFF, 8'hFF, 8'hFE, 8'h01, 3'b000, 1);
        run("add_ovf",   4'd0, 8'h7F, 8'h01, 8'h80, 8'h00, 3'b100, 1);
        run("sub_zero",  4'd1, 8'h01, 8'h01, 8'h00, 8'h00, 3'b010, 1);
        run("sub_brw",   4'd1, 8'h00, 8'h01, 8'hFF, 8'h01, 3'b000, 1);
        run("sub_ovf",   4'd1, 8'h80, 8'h01, 8'h7F, 8'h00, 3'b100, 1);
        run("and",       4'd2, 8'hCC, 8'hAA, 8'h88, 8'h00, 3'b000, 1);
        run("or",        4'd3, 8'hCC, 8'hAA, 8'hEE, 8'h00, 3'b000, 1);
        run("xor",       4'd4, 8'hCC, 8'hAA, 8'h66, 8'h00, 3'b000, 1);
        run("not",       4'd5, 8'h0F, 8'h33, 8'hF0, 8'h00, 3'b000, 1);
        run("shl_3",     4'd6, 8'hF0, 8'h03, 8'h80, 8'h07, 3'b100, 1);
        run("shl_wrap",  4'd6, 8'h81, 8'h09, 8'h02, 8'h01, 3'b100, 1);
        run("shl_0",     4'd6, 8'h05, 8'h00, 8'h05, 8'h00, 3'b000, 1);
        run("shr_4",     4'd7, 8'hF0, 8'h04, 8'h0F, 8'h00, 3'b000, 1);
        run("shr_7",     4'd7, 8'h80, 8'h0F, 8'h01, 8'h00, 3'b000, 1);
        run("mul_75_25", 4'd8, 8'd75, 8'd25, 8'h53, 8'h07, 3'b100, 8);
        run("mul_ff_ff", 4'd8, 8'hFF, 8'hFF, 8'h01, 8'hFE, 3'b100, 8);
        run("mul_zero",  4'd8, 8'h00, 8'h05, 8'h00, 8'h00, 3'b010, 8);
        run("mul_255",   4'd8, 8'h0F, 8'h11, 8'hFF, 8'h00, 3'b000, 8);
        run("div_75_25", 4'd9, 8'd75, 8'd25, 8'h03, 8'h00, 3'b000, 8);
        run("div_200_7", 4'd9, 8'd200, 8'd7, 8'h1C, 8'h04, 3'b000, 8);
        run("div_small", 4'd9, 8'd5, 8'd9, 8'h00, 8'h05, 3'b000, 8);
        run("div_by_0",  4'd9, 8'd75, 8'd0, 8'hFF, 8'h4B, 3'b100, 1);
        run("ill_f",     4'hF, 8'h12, 8'h34, 8'h00, 8'h00, 3'b011, 1);
        run("ill_a",     4'hA, 8'hFF, 8'hFF, 8'h00, 8'h00, 3'b011, 1);

        // Stall the consumer while the source keeps pushing new requests.
        send(4'd8, 8'd75, 8'd25, lat, rdy);
        chk("hold.lat", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            bus.data0       = 8'(i * 37 + 1);
            bus.instruction = 16'h0000;
            bus.in_valid    = 1'b1;
            tick();
            chk("hold.lo", 32'(bus.res_lo), 32'h53);
            chk("hold.hi", 32'(bus.res_hi), 32'h07);
            chk("hold.hs", 32'({bus.out_valid, bus.in_ready}), 32'b10);
        end
        bus.data0     = 8'd2;
        bus.data1     = 8'd3;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("hold.consume", 32'({bus.out_valid, bus.in_ready}), 32'b01);
        tick();
        bus.in_valid = 1'b0;
        chk("hold.next.ov", 32'(bus.out_valid), 32'd1);
        chk("hold.next.lo", 32'(bus.res_lo), 32'h05);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Abort a multiply partway through with an async reset pulse.
        bus.instruction = 16'h8000;
        bus.data0       = 8'd75;
        bus.data1       = 8'd25;
        bus.in_valid    = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        chk("rst.busy", 32'({bus.out_valid, bus.in_ready}), 32'b00);
        rst_n = 1'b0;
        #1;
        chk("rst.hs", 32'({bus.in_ready, bus.out_valid}), 32'b10);
        chk("rst.lo", 32'(bus.res_lo), 32'h0);
        chk("rst.hi", 32'(bus.res_hi), 32'h0);
        chk("rst.flags", 32'({bus.of, bus.zf, bus.err}), 32'b000);
        #2;
        rst_n = 1'b1;
        repeat (10) begin
            tick();
            chk("rst.after", 32'(bus.out_valid), 32'd0);
        end
        run("add_2_3", 4'd0, 8'd2, 8'd3, 8'h05, 8'h00, 3'b000, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/big_alu_seq.md
Name: big_alu_seq

Overview:
- Parametrised, handshaked successor to the combinational big ALU.
- Decodes a 16-bit instruction and operates on two WIDTH-bit operands.
- Adds multi-cycle shift-add multiply and restoring divide; all results and flags are registered.
- Sits between the instruction/operand source and the result consumer, with valid/ready flow control on both sides.

Parameters:
- WIDTH, 8, operand width in bits (≥4).
- INSTR_W, 16, instruction width; the opcode is bits [INSTR_W-1:INSTR_W-4].

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instruction  in  INSTR_W  opcode field in the top 4 bits; the other bits are ignored.
- data0  in  WIDTH  operand A.
- data1  in  WIDTH  operand B.
- in_valid  in  1  instruction and operands are valid.
- in_ready  out  1  block accepts this cycle.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer takes the result.
- res_lo  out  WIDTH  low result word.
- res_hi  out  WIDTH  high result word.
- of  out  1  overflow.
- zf  out  1  {res_hi,res_lo} == 0.
- err  out  1  illegal opcode.

Behaviour:
- Reset: async on rst_n low. State goes to IDLE. in_ready=1, out_valid=0, res_lo=res_hi=0, of=0, zf=0, err=0, iteration counter=0.
- States:
  - IDLE: in_ready=1. Accept when in_valid. Operands and opcode are captured at the accept edge.
    - MUL/DIV with a nonzero divisor -> CALC.
    - Any other opcode, including DIV by zero -> DONE.
  - CALC: in_ready=0. One bit per cycle; counter runs 0..WIDTH-1. Transition to DONE on the edge that completes iteration WIDTH-1.
  - DONE: in_ready=0, out_valid=1. Outputs are held stable until out_ready is high; that edge returns to IDLE.
- No accept in DONE. A back-to-back instruction is accepted at the earliest the cycle after the result is consumed.
- Latency from accept edge to out_valid high: 1 cycle for single-cycle ops, WIDTH cycles for MUL/DIV.
- Opcodes (unsigned unless stated):
  - 0 ADD: res_lo = A+B mod 2^WIDTH, res_hi = {0…,carry}, of = signed overflow.
  - 1 SUB: res_lo = A-B, res_hi = {0…,borrow}, of = signed overflow.
  - 2 AND, 3 OR, 4 XOR: res_lo = bitwise result, res_hi = 0, of = 0.
  - 5 NOT: res_lo = ~A, res_hi = 0.
  - 6 SHL: res_lo = A << B[$clog2(WIDTH)-1:0], res_hi = bits shifted out, of = (res_hi != 0).
  - 7 SHR: logical shift right, res_hi = 0, of = 0.
  - 8 MUL: {res_hi,res_lo} = A*B (2·WIDTH bits), of = (res_hi != 0).
  - 9 DIV: res_lo = quotient, res_hi = remainder, of = 0.
    - B == 0: res_lo = all ones, res_hi = A, of = 1, 1-cycle path.
  - 10–15: illegal. Result 0, of = 0, zf = 1, err = 1, 1-cycle path.
- zf and err are computed from the final result; err = 0 for all legal opcodes.
- Input changes while in CALC or DONE have no effect; operands are latched.
- rst_n low mid-CALC or in DONE: immediate abort to the reset values. The pending result is discarded.
- in_valid and out_ready high together in DONE: only the result is consumed; the new request waits for IDLE.

Decomposition:
- Package big_alu_pkg:
  - opcode enum (OP_ADD..OP_DIV).
  - state enum (IDLE, CALC, DONE).
  - OPC_W = 4 constant.
- Sub-module big_alu_iter(WIDTH): shared shift-add/restoring-subtract datapath for MUL/DIV. It has start/busy/done, its own counter, and outputs hi/lo.
- The top level holds the FSM, single-cycle ops, flags and the output registers.

Test Plan:
- WIDTH=8, ADD, A=255, B=255 -> after 1 cycle: res_lo=0xFE, res_hi=0x01, of=0, zf=0.
- MUL A=75, B=25 -> out_valid exactly 8 cycles after accept: res_lo=0x53, res_hi=0x07, of=1. in_ready stays 0 throughout.
- DIV A=75, B=25 -> res_lo=3, res_hi=0, zf=0. DIV A=75, B=0 -> 1 cycle: res_lo=0xFF, res_hi=75, of=1.
- SUB A=1, B=1 -> res_lo=0, zf=1, of=0. Opcode 0xF -> err=1, zf=1.
- Hold out_ready=0 for 5 cycles after out_valid while changing data0/instruction -> outputs stable, in_ready=0. Result consumed on the first out_ready edge.
- Pulse rst_n low at cycle 4 of a MUL -> outputs go to reset values immediately. Next ADD 2+3 completes normally with res_lo=5.
